// File: rtl/add_seq_ctrl_if.sv
// Request/result bundle for the byte-serial add/subtract controller.
// The master drives requests and result acceptance; the slave is the controller.
interface add_seq_ctrl_if #(
  parameter int NBYTES = 4
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [8*NBYTES-1:0]   a;
  logic [8*NBYTES-1:0]   b;
  logic                  sub;
  logic                  out_valid;
  logic                  out_ready;
  logic [8*NBYTES-1:0]   sum;
  logic                  cout;
  logic                  ovf;
  logic                  busy;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/add_seq_ctrl.sv
// Byte-serial add/subtract controller: one 8-bit ripple-carry adder is reused
// once per clock, LSB byte first, behind a valid/ready request/result handshake.
module full_adder_RCA8bit (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);
  // Ripple the carry bit by bit through eight full adders.
  always_comb begin
    logic [8:0] c;
    c     = 9'd0;
    c[0]  = cin_i;
    sum_o = 8'd0;
    for (int i = 0; i < 8; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = c[8];
  end
endmodule

module add_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input logic          clk,
  input logic          rst_n,
  add_seq_ctrl_if.slave bus
);
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic                    carry_q, carry_d;
  logic [NBYTES-1:0][7:0]  a_q, a_d;
  logic [NBYTES-1:0][7:0]  b_q, b_d;
  logic [NBYTES-1:0][7:0]  sum_q, sum_d;
  logic                    sub_q, sub_d;
  logic                    cout_q, cout_d;
  logic                    ovf_q, ovf_d;

  logic [7:0]              add_a_s;
  logic [7:0]              add_b_s;
  logic [7:0]              add_sum_s;
  logic                    add_cout_s;
  logic                    msb_cin_s;

  // Subtraction is A + ~B + 1: B is inverted here and the +1 enters as the initial carry.
  assign add_a_s = a_q[idx_q];
  assign add_b_s = sub_q ? ~b_q[idx_q] : b_q[idx_q];

  full_adder_RCA8bit u_adder (
    .a_i    (add_a_s),
    .b_i    (add_b_s),
    .cin_i  (carry_q),
    .sum_o  (add_sum_s),
    .cout_o (add_cout_s)
  );

  // Carry into bit 7 recovered from the sum bit, so the adder needs no extra port.
  assign msb_cin_s = add_sum_s[7] ^ add_a_s[7] ^ add_b_s[7];

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

  // Next-state and datapath updates for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sub_d   = bus.sub;
          idx_d   = '0;
          carry_d = bus.sub;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[idx_q] = add_sum_s;
        carry_d      = add_cout_s;
        if (idx_q == LAST_IDX) begin
          cout_d  = add_cout_s;
          ovf_d   = msb_cin_s ^ add_cout_s;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDXW'(1'b1);
          state_d = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed self-checking bench for add_seq_ctrl (NBYTES=4): vector table plus
// hand sequences for result back-pressure and mid-operation reset.
module tb_add_seq_ctrl;
  logic clk;
  logic rst_n;

  add_seq_ctrl_if #(.NBYTES(4)) bus_if ();

  add_seq_ctrl #(.NBYTES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] s;
    logic        c;
    logic        o;
  } vec_t;

  vec_t vecs[8];
  int   total;
  int   bad;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_op(input vec_t v);
    @(negedge clk);
    check("in_ready_before_req", {63'd0, bus_if.in_ready}, 64'd1);
    bus_if.a        = v.a;
    bus_if.b        = v.b;
    bus_if.sub      = v.sub;
    bus_if.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    bus_if.a        = ~v.a;
    bus_if.b        = ~v.b;
    bus_if.sub      = ~v.sub;
    check("busy_after_accept", {63'd0, bus_if.busy}, 64'd1);
    check("in_ready_in_run", {63'd0, bus_if.in_ready}, 64'd0);
  endtask

  task automatic wait_result(input vec_t v, input string tag);
    int cyc;
    cyc = 0;
    while (bus_if.out_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd4);
    check({tag, "_sum"}, {32'd0, bus_if.sum}, {32'd0, v.s});
    check({tag, "_cout"}, {63'd0, bus_if.cout}, {63'd0, v.c});
    check({tag, "_ovf"}, {63'd0, bus_if.ovf}, {63'd0, v.o});
  endtask

  task automatic handshake();
    @(negedge clk);
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.out_ready = 1'b0;
    check("out_valid_after_hs", {63'd0, bus_if.out_valid}, 64'd0);
    check("in_ready_after_hs", {63'd0, bus_if.in_ready}, 64'd1);
  endtask

  task automatic do_op(input vec_t v, input string tag);
    start_op(v);
    wait_result(v, tag);
    handshake();
  endtask

  initial begin
    int seen;
    total = 0;
    bad   = 0;
    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[3] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[4] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[5] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
    vecs[6] = '{32'h00000010, 32'h00000010, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[7] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};

    rst_n            = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    bus_if.a         = 32'd0;
    bus_if.b         = 32'd0;
    bus_if.sub       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_sum", {32'd0, bus_if.sum}, 64'd0);
    check("rst_out_valid", {63'd0, bus_if.out_valid}, 64'd0);
    check("rst_busy", {63'd0, bus_if.busy}, 64'd0);
    check("rst_cout_ovf", {62'd0, bus_if.cout, bus_if.ovf}, 64'd0);
    check("rst_in_ready", {63'd0, bus_if.in_ready}, 64'd1);

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-pressure: result held three cycles while new requests are offered.
    start_op(vecs[5]);
    wait_result(vecs[5], "hold");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus_if.in_valid = 1'b1;
      bus_if.a        = 32'hDEADBEEF;
      bus_if.b        = 32'h01020304;
      bus_if.sub      = 1'b1;
      @(posedge clk);
      #1;
      check("hold_sum", {32'd0, bus_if.sum}, {32'd0, vecs[5].s});
      check("hold_flags", {62'd0, bus_if.cout, bus_if.ovf}, {62'd0, vecs[5].c, vecs[5].o});
      check("hold_out_valid", {63'd0, bus_if.out_valid}, 64'd1);
      check("hold_in_ready", {63'd0, bus_if.in_ready}, 64'd0);
    end
    bus_if.in_valid = 1'b0;
    handshake();
    do_op(vecs[2], "after_hold");

    // Reset asserted while byte index 2 is being processed.
    start_op(vecs[1]);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_sum", {32'd0, bus_if.sum}, 64'd0);
    check("abort_out_valid", {63'd0, bus_if.out_valid}, 64'd0);
    check("abort_busy", {63'd0, bus_if.busy}, 64'd0);
    check("abort_cout_ovf", {62'd0, bus_if.cout, bus_if.ovf}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_in_ready", {63'd0, bus_if.in_ready}, 64'd1);
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus_if.out_valid === 1'b1 || bus_if.busy === 1'b1) seen++;
    end
    check("abort_no_result", 64'(seen), 64'd0);
    do_op(vecs[4], "after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
